// File: rtl/button_scan_pkg.sv
// Shared definitions for the time-multiplexed button debounce controller:
// default parameters, event encoding and the index-width helper.
package button_scan_pkg;

   localparam int DEF_NUM_BTN = 4;
   localparam int DEF_DIV     = 50000;
   localparam int DEF_HIST    = 4;

   localparam logic EVT_PRESS   = 1'b1;
   localparam logic EVT_RELEASE = 1'b0;

   // Number of bits needed to hold the values 0 .. value-1.
   function automatic int clog2(input int value);
      int width;
      width = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts 0..DIV-1 and flags the last count as the scan tick.
module scan_prescaler
   import button_scan_pkg::*;
#(
   parameter int DIV = DEF_DIV
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   // A single-cycle period still needs a one-bit counter that stays at zero.
   localparam int CW = (DIV > 1) ? clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/button_scan_ctrl.sv
// Round-robin debounce controller: one shared history filter serves all buttons
// and level changes are reported through a single-entry valid/ready event port.
module button_scan_ctrl
   import button_scan_pkg::*;
#(
   parameter int NUM_BTN = DEF_NUM_BTN,
   parameter int DIV     = DEF_DIV,
   parameter int HIST    = DEF_HIST,
   parameter int IDXW    = clog2(NUM_BTN)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] clean,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [IDXW-1:0]    evt_idx,
   output logic               evt_press,
   output logic               evt_drop
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BTN - 1);

   logic [NUM_BTN-1:0] sync_a;
   logic [NUM_BTN-1:0] sync_b;
   logic [HIST-1:0]    hist [NUM_BTN];
   logic [IDXW-1:0]    idx;
   logic               tick;
   logic [HIST-1:0]    hist_new;
   logic               clean_next;
   logic               evt_new;

   scan_prescaler #(
      .DIV(DIV)
   ) u_prescaler (
      .clock(clock),
      .reset(reset),
      .tick (tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
      end
   end

   // The filter judges the history including this slot's sample, so a level
   // change is seen in the same slot that completes the window.
   always_comb begin
      hist_new   = {hist[idx][HIST-2:0], sync_b[idx]};
      clean_next = clean[idx];
      if (&hist_new) begin
         clean_next = 1'b1;
      end else if (~|hist_new) begin
         clean_next = 1'b0;
      end
      evt_new = tick && (clean_next != clean[idx]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            hist[i] <= '0;
         end
         clean <= '0;
         idx   <= '0;
      end else if (tick) begin
         hist[idx]  <= hist_new;
         clean[idx] <= clean_next;
         idx        <= (idx == LAST_IDX) ? '0 : idx + IDXW'(1);
      end
   end

   // A new event may replace one that is leaving in the same cycle; only a
   // stalled register forces the new event to be dropped.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         evt_valid <= 1'b0;
         evt_idx   <= '0;
         evt_press <= EVT_RELEASE;
         evt_drop  <= 1'b0;
      end else begin
         evt_drop <= 1'b0;
         if (evt_new && (!evt_valid || evt_ready)) begin
            evt_valid <= 1'b1;
            evt_idx   <= idx;
            evt_press <= clean_next ? EVT_PRESS : EVT_RELEASE;
         end else begin
            if (evt_new) begin
               evt_drop <= 1'b1;
            end
            if (evt_ready) begin
               evt_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Self-checking bench for button_scan_ctrl: two instances (DIV=3 and DIV=1)
// share stimulus and are compared every cycle against a run-length reference model.
module tb_button_scan_ctrl;

   localparam int NB   = 4;
   localparam int HIST = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [NB-1:0] btn_raw = '0;
   logic          evt_ready = 1'b0;

   logic [NB-1:0] clean_a, clean_b;
   logic          valid_a, valid_b;
   logic [1:0]    idx_a, idx_b;
   logic          press_a, press_b;
   logic          drop_a, drop_b;

   int tests = 0;
   int fails = 0;

   // Reference model state: edge count since reset release, delayed raw
   // samples, and per instance the run length of equal samples per button.
   int            e;
   logic [NB-1:0] raw_q[$];
   int            divs[2] = '{3, 1};
   bit            m_clean[2][NB];
   bit            m_last[2][NB];
   int            m_run[2][NB];
   bit            m_vld[2];
   int            m_idx[2];
   bit            m_press[2];
   bit            m_drop[2];

   always #5 clock = ~clock;

   button_scan_ctrl #(.NUM_BTN(NB), .DIV(3), .HIST(HIST)) dut_a (
      .clock(clock), .reset(reset), .btn_raw(btn_raw), .clean(clean_a),
      .evt_valid(valid_a), .evt_ready(evt_ready), .evt_idx(idx_a),
      .evt_press(press_a), .evt_drop(drop_a)
   );

   button_scan_ctrl #(.NUM_BTN(NB), .DIV(1), .HIST(HIST)) dut_b (
      .clock(clock), .reset(reset), .btn_raw(btn_raw), .clean(clean_b),
      .evt_valid(valid_b), .evt_ready(evt_ready), .evt_idx(idx_b),
      .evt_press(press_b), .evt_drop(drop_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cleanVec(input int k);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NB; i++) v[i] = m_clean[k][i];
      return v;
   endfunction

   task automatic modelReset();
      e = 0;
      raw_q.delete();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NB; i++) begin
            m_clean[k][i] = 1'b0;
            m_last[k][i]  = 1'b0;
            m_run[k][i]   = HIST;
         end
         m_vld[k]   = 1'b0;
         m_idx[k]   = 0;
         m_press[k] = 1'b0;
         m_drop[k]  = 1'b0;
      end
   endtask

   // One rising edge: every DIV-th edge ends a slot for button (slot number mod NB),
   // which sees the raw level from two edges earlier.
   task automatic modelStep();
      logic [NB-1:0] smp;
      e++;
      raw_q.push_back(btn_raw);
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      smp = (raw_q.size() == 3) ? raw_q[0] : '0;
      for (int k = 0; k < 2; k++) begin
         int b;
         bit s;
         bit new_evt;
         b = 0;
         s = 1'b0;
         new_evt = 1'b0;
         m_drop[k] = 1'b0;
         if (e % divs[k] == 0) begin
            b = (e / divs[k] - 1) % NB;
            s = smp[b];
            if (s == m_last[k][b]) begin
               m_run[k][b]++;
            end else begin
               m_last[k][b] = s;
               m_run[k][b]  = 1;
            end
            if (m_run[k][b] >= HIST && m_clean[k][b] != s) begin
               new_evt = 1'b1;
               m_clean[k][b] = s;
            end
         end
         if (new_evt) begin
            if (!m_vld[k] || evt_ready) begin
               m_vld[k]   = 1'b1;
               m_idx[k]   = b;
               m_press[k] = s;
            end else begin
               m_drop[k] = 1'b1;
            end
         end else if (evt_ready) begin
            m_vld[k] = 1'b0;
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("a_clean", 32'(clean_a), cleanVec(0));
      checkOutput("a_valid", 32'(valid_a), 32'(m_vld[0]));
      checkOutput("a_drop", 32'(drop_a), 32'(m_drop[0]));
      checkOutput("a_tick", 32'(dut_a.tick), (e % 3 == 2) ? 1 : 0);
      checkOutput("a_scan_idx", 32'(dut_a.idx), (e / 3) % NB);
      if (m_vld[0]) begin
         checkOutput("a_evt_idx", 32'(idx_a), m_idx[0]);
         checkOutput("a_evt_press", 32'(press_a), 32'(m_press[0]));
      end
      checkOutput("b_clean", 32'(clean_b), cleanVec(1));
      checkOutput("b_valid", 32'(valid_b), 32'(m_vld[1]));
      checkOutput("b_drop", 32'(drop_b), 32'(m_drop[1]));
      checkOutput("b_tick", 32'(dut_b.tick), 1);
      checkOutput("b_scan_idx", 32'(dut_b.idx), e % NB);
      if (m_vld[1]) begin
         checkOutput("b_evt_idx", 32'(idx_b), m_idx[1]);
         checkOutput("b_evt_press", 32'(press_b), 32'(m_press[1]));
      end
   endtask

   task automatic applyStimulus(input logic [NB-1:0] raw, input logic rdy, input int n);
      btn_raw   = raw;
      evt_ready = rdy;
      repeat (n) begin
         @(posedge clock);
         modelStep();
         @(negedge clock);
         checkAll();
      end
   endtask

   // Reset is raised between edges so its asynchronous effect is checked alone.
   task automatic doReset(input logic [NB-1:0] raw);
      reset     = 1'b1;
      btn_raw   = raw;
      evt_ready = 1'b0;
      #1;
      checkOutput("rst_a_outputs", {clean_a, valid_a, idx_a, press_a, drop_a}, 0);
      checkOutput("rst_b_outputs", {clean_b, valid_b, idx_b, press_b, drop_b}, 0);
      modelReset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [NB-1:0] rnd_raw;
      int            len;

      #1;
      doReset(4'b0000);
      applyStimulus(4'b0000, 1'b0, 100);

      doReset(4'b0100);
      applyStimulus(4'b0100, 1'b1, 44);
      checkOutput("press_not_yet", 32'(clean_a), 0);
      applyStimulus(4'b0100, 1'b1, 1);
      checkOutput("press_clean", 32'(clean_a), 32'h4);
      checkOutput("press_valid", 32'(valid_a), 1);
      checkOutput("press_idx", 32'(idx_a), 2);
      checkOutput("press_dir", 32'(press_a), 1);
      applyStimulus(4'b0100, 1'b1, 1);
      checkOutput("press_consumed", 32'(valid_a), 0);

      applyStimulus(4'b0110, 1'b1, 60);
      checkOutput("bounce_pre", 32'(clean_a), 32'h6);
      for (int t = 0; t < 8; t++) begin
         applyStimulus((t % 2 == 1) ? 4'b0110 : 4'b0100, 1'b1, 12);
      end
      checkOutput("bounce_a_hold", 32'(clean_a), 32'h6);
      checkOutput("bounce_b_hold", 32'(clean_b), 32'h6);

      applyStimulus(4'b0111, 1'b1, 60);
      applyStimulus(4'b0110, 1'b1, 60);
      checkOutput("release_clean", 32'(clean_a), 32'h6);

      doReset(4'b0011);
      applyStimulus(4'b0011, 1'b0, 17);
      checkOutput("div1_first_idx", 32'(idx_b), 0);
      applyStimulus(4'b0011, 1'b1, 1);
      checkOutput("div1_same_cycle_valid", 32'(valid_b), 1);
      checkOutput("div1_same_cycle_idx", 32'(idx_b), 1);
      checkOutput("div1_same_cycle_nodrop", 32'(drop_b), 0);
      applyStimulus(4'b0011, 1'b0, 24);
      checkOutput("bp_drop", 32'(drop_a), 1);
      checkOutput("bp_clean", 32'(clean_a), 32'h3);
      checkOutput("bp_held_idx", 32'(idx_a), 0);
      applyStimulus(4'b0011, 1'b0, 1);
      checkOutput("bp_drop_pulse", 32'(drop_a), 0);
      checkOutput("bp_still_valid", 32'(valid_a), 1);

      applyStimulus(4'b1011, 1'b0, 20);
      doReset(4'b1000);
      applyStimulus(4'b1000, 1'b0, 47);
      checkOutput("rst_refill_not_yet", 32'(clean_a), 0);
      applyStimulus(4'b1000, 1'b0, 1);
      checkOutput("rst_refill_clean", 32'(clean_a), 32'h8);
      checkOutput("rst_refill_idx", 32'(idx_a), 3);

      for (int s = 0; s < 40; s++) begin
         rnd_raw = NB'($urandom_range(0, 15));
         len     = $urandom_range(1, 50);
         for (int c = 0; c < len; c++) begin
            applyStimulus(rnd_raw, 1'($urandom_range(0, 1)), 1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
